duck_controller: RTL and testbench

DUCK_CONTROLLER -- requirements
Module: duck_controller

---
 rtl/duck_pkg.sv | 32 +++
 rtl/duck_controller_lfsr16.sv | 28 ++
 rtl/duck_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_duck_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// duck_pkg: definitions shared by the duck sprite controller.
//   duck_state_t   - controller FSM states
//   FRAME_*        - sprite frame indices presented on DuckFrame
//   SPRITE_SIZE    - square sprite edge length in pixels (hit box)
//   LFSR_SEED      - power-up / reset value of the spawn LFSR
//   color_from_bits- maps two random bits onto the three duck colours
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLY,
    ST_HIT,
    ST_FALL,
    ST_ESCAPE
  } duck_state_t;

  localparam int SPRITE_SIZE = 64;

  localparam logic [5:0] FRAME_IDLE     = 6'd0;
  localparam logic [5:0] FRAME_FLY_LEFT = 6'd3;  // offset added to 0..2 when flying left
  localparam logic [5:0] FRAME_HIT      = 6'd6;
  localparam logic [5:0] FRAME_FALL     = 6'd7;
  localparam logic [5:0] FRAME_ESCAPE   = 6'd8;  // 8 / 9 alternate

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Colour code 3 is unused by the colour mapper, so fold it onto black.
  function automatic logic [1:0] color_from_bits(input logic [1:0] bits);
    return (bits == 2'd3) ? 2'd0 : bits;
  endfunction

endpackage

// File: rtl/duck_controller_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// The polynomial is maximal length, so from the non-zero seed it never hits 0.
//   clk   in  1   clock
//   reset in  1   asynchronous active-high reset, loads LFSR_SEED
//   q     out 16  current LFSR value
module lfsr16
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/duck_controller.sv
// duck_controller: position, animation and shot handling for one duck sprite.
//   ANIM_Clk        in  1   clock (one step per cycle)
//   Reset           in  1   asynchronous active-high reset
//   Start           in  1   spawn request, honoured only while idle
//   MouseButtons    in  s8  8'd2 = trigger pressed
//   CursorX/Y       in  10  crosshair position
//   Duck_X/Y        out 10  sprite top-left corner
//   DuckFrame       out 6   sprite frame index
//   Duck_color      out 2   0 black, 1 red, 2 pink
//   duckresetSignal out 1   1 hides the duck (idle)
//   Hit / Escaped   out 1   one-cycle pulses
//   ShotsLeft       out 2   remaining shots for this duck
// All outputs are registered; each comes straight from a flop.
module duck_controller
  import duck_pkg::*;
#(
  parameter int X_MAX      = 576,
  parameter int Y_TOP      = 40,
  parameter int Y_BOT      = 280,
  parameter int GROUND_Y   = 380,
  parameter int SPEED      = 2,
  parameter int FLY_CYCLES = 600,
  parameter int HIT_HOLD   = 30
) (
  input  logic              ANIM_Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic signed [7:0] MouseButtons,
  input  logic [9:0]        CursorX,
  input  logic [9:0]        CursorY,
  output logic [9:0]        Duck_X,
  output logic [9:0]        Duck_Y,
  output logic [5:0]        DuckFrame,
  output logic [1:0]        Duck_color,
  output logic              duckresetSignal,
  output logic              Hit,
  output logic              Escaped,
  output logic [1:0]        ShotsLeft
);

  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] SPEED_11 = 11'(SPEED);
  localparam logic [9:0]  SPEED_10 = 10'(SPEED);
  localparam logic [9:0]  Y_TOP_W  = 10'(Y_TOP);
  localparam logic [9:0]  Y_BOT_W  = 10'(Y_BOT);
  localparam logic [9:0]  GROUND_W = 10'(GROUND_Y);
  localparam logic [15:0] FLY_LAST = 16'(FLY_CYCLES - 1);
  localparam logic [15:0] HIT_LAST = 16'(HIT_HOLD - 1);
  localparam logic [9:0]  SPRITE_W = 10'(SPRITE_SIZE);

  logic [15:0] lfsr;
  logic [3:0]  lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (ANIM_Clk),
    .reset (Reset),
    .q     (lfsr)
  );

  assign lfsr_unused = lfsr[15:12];

  duck_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        left_q, left_d, up_q, up_d;
  logic [1:0]  shots_q, shots_d, color_q, color_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  anim_cnt_q, anim_cnt_d;
  logic [1:0]  anim_phase_q, anim_phase_d;
  logic        btn_q, btn_d;
  logic        hit_q, hit_d, esc_q, esc_d;
  logic [5:0]  frame_q, frame_d;
  logic        hide_q, hide_d;

  logic        pressed, shot, on_target, up_now;
  logic [9:0]  rel_x, rel_y, y_fall;
  logic [10:0] x_right;

  always_comb begin
    pressed   = (MouseButtons == 8'sd2);
    shot      = pressed && !btn_q;     // rising edge only: a held trigger fires once
    btn_d     = pressed;
    // Wrap-around differences: a cursor left of / above the duck becomes huge.
    rel_x     = CursorX - x_q;
    rel_y     = CursorY - y_q;
    on_target = (rel_x < SPRITE_W) && (rel_y < SPRITE_W);
    x_right   = {1'b0, x_q} + SPEED_11;
    y_fall    = y_q + 10'd4;
    up_now    = up_q;

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    left_d       = left_q;
    up_d         = up_q;
    shots_d      = shots_q;
    color_d      = color_q;
    timer_d      = timer_q;
    anim_cnt_d   = anim_cnt_q;
    anim_phase_d = anim_phase_q;
    hit_d        = 1'b0;
    esc_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d      = ST_FLY;
          x_d          = {1'b0, lfsr[8:0]} + 10'd32;
          y_d          = Y_BOT_W;
          color_d      = color_from_bits(lfsr[10:9]);
          left_d       = lfsr[11];
          up_d         = 1'b1;
          shots_d      = 2'd3;
          timer_d      = 16'd0;
          anim_cnt_d   = 3'd0;
          anim_phase_d = 2'd0;
        end
      end

      ST_FLY: begin
        timer_d    = timer_q + 16'd1;
        anim_cnt_d = anim_cnt_q + 3'd1;
        if (anim_cnt_q == 3'd7)
          anim_phase_d = (anim_phase_q == 2'd2) ? 2'd0 : anim_phase_q + 2'd1;

        if (shot && (shots_q != 2'd0)) begin
          shots_d = shots_q - 2'd1;
          if (on_target) begin
            state_d = ST_HIT;
            hit_d   = 1'b1;
          end else if (shots_q == 2'd1) begin
            state_d = ST_ESCAPE;
          end
        end
        // A hit on the final flight cycle wins over the timeout.
        if ((state_d == ST_FLY) && (timer_q == FLY_LAST))
          state_d = ST_ESCAPE;

        if (state_d != ST_FLY) begin
          // Leaving flight: the duck stays where the shot was judged.
          timer_d      = 16'd0;
          anim_cnt_d   = 3'd0;
          anim_phase_d = 2'd0;
        end else begin
          // At a horizontal wall the direction flips and X waits one cycle.
          if (left_q) begin
            if (x_q < SPEED_10) left_d = 1'b0;
            else                x_d    = x_q - SPEED_10;
          end else begin
            if (x_right > X_MAX_W) left_d = 1'b1;
            else                   x_d    = x_right[9:0];
          end
          if (y_q <= Y_TOP_W)      up_now = 1'b0;
          else if (y_q >= Y_BOT_W) up_now = 1'b1;
          up_d = up_now;
          y_d  = up_now ? (y_q - SPEED_10) : (y_q + SPEED_10);
        end
      end

      ST_HIT: begin
        if (timer_q == HIT_LAST) begin
          state_d = ST_FALL;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_FALL: begin
        // The clamped ground row is shown for one cycle before hiding.
        if (y_q >= GROUND_W) state_d = ST_IDLE;
        else                 y_d = (y_fall >= GROUND_W) ? GROUND_W : y_fall;
      end

      ST_ESCAPE: begin
        anim_cnt_d = anim_cnt_q + 3'd1;
        if (anim_cnt_q == 3'd7)
          anim_phase_d = {1'b0, ~anim_phase_q[0]};
        if (y_q < SPEED_10) begin
          state_d = ST_IDLE;
          esc_d   = 1'b1;
        end else begin
          y_d = y_q - SPEED_10;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame follows the next state so it lines up with the registered position.
    case (state_d)
      ST_FLY:    frame_d = {4'b0, anim_phase_d} + (left_d ? FRAME_FLY_LEFT : 6'd0);
      ST_HIT:    frame_d = FRAME_HIT;
      ST_FALL:   frame_d = FRAME_FALL;
      ST_ESCAPE: frame_d = FRAME_ESCAPE + {5'b0, anim_phase_d[0]};
      default:   frame_d = FRAME_IDLE;
    endcase
    hide_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      left_q       <= 1'b0;
      up_q         <= 1'b0;
      shots_q      <= 2'd3;
      color_q      <= 2'd0;
      timer_q      <= '0;
      anim_cnt_q   <= '0;
      anim_phase_q <= '0;
      btn_q        <= 1'b0;
      hit_q        <= 1'b0;
      esc_q        <= 1'b0;
      frame_q      <= FRAME_IDLE;
      hide_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      left_q       <= left_d;
      up_q         <= up_d;
      shots_q      <= shots_d;
      color_q      <= color_d;
      timer_q      <= timer_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_phase_q <= anim_phase_d;
      btn_q        <= btn_d;
      hit_q        <= hit_d;
      esc_q        <= esc_d;
      frame_q      <= frame_d;
      hide_q       <= hide_d;
    end
  end

  assign Duck_X          = x_q;
  assign Duck_Y          = y_q;
  assign DuckFrame       = frame_q;
  assign Duck_color      = color_q;
  assign duckresetSignal = hide_q;
  assign Hit             = hit_q;
  assign Escaped         = esc_q;
  assign ShotsLeft       = shots_q;

endmodule

// File: tb/tb_duck_controller.sv
// tb_duck_controller: directed scenarios for duck_controller, checked every
// cycle against a behavioural duck model plus literal expectations.
module tb_duck_controller;

  localparam int X_MAX = 576, Y_TOP = 40, Y_BOT = 280, GROUND_Y = 380;
  localparam int SPEED = 2, FLY_CYCLES = 600, HIT_HOLD = 30;
  localparam int M_IDLE = 0, M_FLY = 1, M_HIT = 2, M_FALL = 3, M_ESC = 4;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic signed [7:0] MouseButtons = 8'sd0;
  logic [9:0]        CursorX = 10'd0, CursorY = 10'd0;
  logic [9:0]        Duck_X, Duck_Y;
  logic [5:0]        DuckFrame;
  logic [1:0]        Duck_color, ShotsLeft;
  logic              duckresetSignal, Hit, Escaped;

  int n_cmp = 0;
  int n_fail = 0;

  duck_controller #(
    .X_MAX(X_MAX), .Y_TOP(Y_TOP), .Y_BOT(Y_BOT), .GROUND_Y(GROUND_Y),
    .SPEED(SPEED), .FLY_CYCLES(FLY_CYCLES), .HIT_HOLD(HIT_HOLD)
  ) dut (
    .ANIM_Clk(clk), .Reset(Reset), .Start(Start), .MouseButtons(MouseButtons),
    .CursorX(CursorX), .CursorY(CursorY), .Duck_X(Duck_X), .Duck_Y(Duck_Y),
    .DuckFrame(DuckFrame), .Duck_color(Duck_color), .duckresetSignal(duckresetSignal),
    .Hit(Hit), .Escaped(Escaped), .ShotsLeft(ShotsLeft)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_mode, m_x, m_y, m_shots, m_col, m_age;
  bit m_left, m_up, m_hitp, m_escp, m_btn;
  bit [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 0; m_y = 0; m_shots = 3; m_col = 0; m_age = 0;
    m_left = 0; m_up = 0; m_hitp = 0; m_escp = 0; m_btn = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    bit pressed, shot;
    int nxt, c;
    pressed = (MouseButtons == 8'sd2);
    shot = pressed && !m_btn;
    m_btn = pressed;
    m_hitp = 0;
    m_escp = 0;
    case (m_mode)
      M_IDLE: if (Start) begin
        m_x = int'(m_lfsr % 512) + 32;
        m_y = Y_BOT;
        c = int'((m_lfsr >> 9) % 4);
        m_col = (c == 3) ? 0 : c;
        m_left = m_lfsr[11];
        m_up = 1;
        m_shots = 3;
        m_mode = M_FLY;
        m_age = 0;
      end
      M_FLY: begin
        nxt = M_FLY;
        if (shot && m_shots > 0) begin
          m_shots--;
          if (((int'(CursorX) - m_x) & 1023) < 64 && ((int'(CursorY) - m_y) & 1023) < 64) begin
            nxt = M_HIT;
            m_hitp = 1;
          end else if (m_shots == 0) nxt = M_ESC;
        end
        if (nxt == M_FLY && m_age == FLY_CYCLES - 1) nxt = M_ESC;
        if (nxt == M_FLY) begin
          if (m_left) begin
            if (m_x - SPEED < 0) m_left = 0; else m_x -= SPEED;
          end else begin
            if (m_x + SPEED > X_MAX) m_left = 1; else m_x += SPEED;
          end
          if (m_y <= Y_TOP) m_up = 0;
          else if (m_y >= Y_BOT) m_up = 1;
          m_y += m_up ? -SPEED : SPEED;
          m_age++;
        end else begin
          m_mode = nxt;
          m_age = 0;
        end
      end
      M_HIT: if (m_age == HIT_HOLD - 1) begin m_mode = M_FALL; m_age = 0; end
             else m_age++;
      M_FALL: if (m_y >= GROUND_Y) m_mode = M_IDLE;
              else m_y = (m_y + 4 > GROUND_Y) ? GROUND_Y : m_y + 4;
      M_ESC: if (m_y < SPEED) begin m_mode = M_IDLE; m_escp = 1; end
             else begin m_y -= SPEED; m_age++; end
      default: m_mode = M_IDLE;
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  function automatic int exp_frame();
    case (m_mode)
      M_FLY:   return (m_age / 8) % 3 + (m_left ? 3 : 0);
      M_HIT:   return 6;
      M_FALL:  return 7;
      M_ESC:   return 8 + (m_age / 8) % 2;
      default: return 0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison, half a period after the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_X", int'(Duck_X), m_x);
      check("cyc_Y", int'(Duck_Y), m_y);
      check("cyc_frame", int'(DuckFrame), exp_frame());
      check("cyc_color", int'(Duck_color), m_col);
      check("cyc_hide", int'(duckresetSignal), (m_mode == M_IDLE) ? 1 : 0);
      check("cyc_hit", int'(Hit), int'(m_hitp));
      check("cyc_esc", int'(Escaped), int'(m_escp));
      check("cyc_shots", int'(ShotsLeft), m_shots);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic aim_and_fire();
    CursorX = 10'(m_x + 10);
    CursorY = 10'(m_y + 10);
    MouseButtons = 8'sd2;
  endtask

  task automatic wait_hidden(input int limit, input string tag, output int esc_seen);
    int n;
    n = 0;
    esc_seen = 0;
    while (duckresetSignal !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    if (Escaped === 1'b1) esc_seen = 1;
    check(tag, int'(duckresetSignal), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_X"}, int'(Duck_X), 0);
    check({tag, "_Y"}, int'(Duck_Y), 0);
    check({tag, "_frame"}, int'(DuckFrame), 0);
    check({tag, "_color"}, int'(Duck_color), 0);
    check({tag, "_hide"}, int'(duckresetSignal), 1);
    check({tag, "_hit"}, int'(Hit), 0);
    check({tag, "_esc"}, int'(Escaped), 0);
    check({tag, "_shots"}, int'(ShotsLeft), 3);
  endtask

  int n6, esc, n_fly, idx, ysave;
  int xq[$];

  initial begin
    // Reset state, then Start sampled on the first edge with the seed value.
    Start = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    Reset = 1'b0;
    step();
    Start = 1'b0;
    $display("[spawn] X=%0d Y=%0d color=%0d frame=%0d", Duck_X, Duck_Y, Duck_color, DuckFrame);
    check("spawn_X", int'(Duck_X), 257);
    check("spawn_Y", int'(Duck_Y), 280);
    check("spawn_hide", int'(duckresetSignal), 0);
    check("spawn_shots", int'(ShotsLeft), 3);
    check("spawn_color", int'(Duck_color), 2);
    check("spawn_frame", int'(DuckFrame), 3);

    // Direct hit, freeze, fall to ground.
    step();
    aim_and_fire();
    step();
    MouseButtons = 8'sd0;
    $display("[hit] Hit=%0d shots=%0d frame=%0d", Hit, ShotsLeft, DuckFrame);
    check("hit_pulse", int'(Hit), 1);
    check("hit_shots", int'(ShotsLeft), 2);
    check("hit_frame", int'(DuckFrame), 6);
    n6 = 1;
    step();
    check("hit_one_cycle", int'(Hit), 0);
    while (DuckFrame == 6'd6 && n6 < 100) begin n6++; step(); end
    check("hit_hold_cycles", n6, 30);
    check("fall_frame", int'(DuckFrame), 7);
    wait_hidden(200, "fall_to_idle", esc);
    $display("[fall] idle at Y=%0d", Duck_Y);
    check("fall_end_Y", int'(Duck_Y), 380);

    // Held trigger counts once, then two more misses -> escape.
    Start = 1'b1; step(); Start = 1'b0;
    CursorX = 10'd0; CursorY = 10'd0; MouseButtons = 8'sd2;
    repeat (50) step();
    $display("[held] shots=%0d", ShotsLeft);
    check("held_shots", int'(ShotsLeft), 2);
    MouseButtons = 8'sd0; step(); MouseButtons = 8'sd2; step();
    check("miss2_shots", int'(ShotsLeft), 1);
    MouseButtons = 8'sd0; step(); MouseButtons = 8'sd2; step();
    MouseButtons = 8'sd0;
    check("miss3_shots", int'(ShotsLeft), 0);
    check("escape_frame", int'(DuckFrame), 8);
    ysave = int'(Duck_Y);
    step();
    check("escape_dy", ysave - int'(Duck_Y), 2);
    wait_hidden(300, "escape_to_idle", esc);
    $display("[escape] Escaped=%0d", esc);
    check("escape_pulse", esc, 1);
    step();
    check("escape_one_cycle", int'(Escaped), 0);
    MouseButtons = 8'sd2; step(); step(); MouseButtons = 8'sd0;
    check("idle_click_shots", int'(ShotsLeft), 0);
    check("idle_click_hide", int'(duckresetSignal), 1);

    // Untouched flight with an odd X: wall bounce at 575, then timeout.
    idx = 0;
    while (m_lfsr[0] != 1'b1 && idx < 20) begin step(); idx++; end
    Start = 1'b1; step(); Start = 1'b0;
    n_fly = 0;
    while (DuckFrame < 6'd6 && duckresetSignal == 1'b0 && n_fly < 700) begin
      xq.push_back(int'(Duck_X));
      n_fly++;
      step();
    end
    $display("[timeout] fly cycles=%0d frame=%0d", n_fly, DuckFrame);
    check("timeout_cycles", n_fly, 600);
    check("timeout_frame", int'(DuckFrame), 8);
    idx = -1;
    for (int i = 0; i + 2 < xq.size(); i++)
      if (idx < 0 && xq[i] == 575) idx = i;
    check("bounce_found", (idx >= 0) ? 1 : 0, 1);
    if (idx >= 0) begin
      $display("[bounce] X: %0d %0d %0d", xq[idx], xq[idx+1], xq[idx+2]);
      check("bounce_hold", xq[idx+1], 575);
      check("bounce_back", xq[idx+2], 573);
    end
    wait_hidden(300, "timeout_escape_idle", esc);

    // Hit on the last flight cycle beats the timeout.
    Start = 1'b1; step(); Start = 1'b0;
    repeat (FLY_CYCLES - 1) step();
    aim_and_fire();
    step();
    MouseButtons = 8'sd0;
    $display("[late hit] Hit=%0d frame=%0d", Hit, DuckFrame);
    check("late_hit_pulse", int'(Hit), 1);
    check("late_hit_frame", int'(DuckFrame), 6);
    wait_hidden(300, "late_hit_idle", esc);
    check("late_hit_no_escape", esc, 0);
    check("late_hit_ground", int'(Duck_Y), 380);

    // Asynchronous reset while falling.
    Start = 1'b1; step(); Start = 1'b0;
    step();
    aim_and_fire();
    step();
    MouseButtons = 8'sd0;
    repeat (HIT_HOLD + 2) step();
    check("pre_reset_fall", int'(DuckFrame), 7);
    Reset = 1'b1;
    #1;
    $display("[reset in fall] X=%0d Y=%0d hide=%0d", Duck_X, Duck_Y, duckresetSignal);
    check_reset_outputs("fall_reset");
    step();
    Reset = 1'b0;
    step();
    check("post_reset_hide", int'(duckresetSignal), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected scenario completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
